// File: rtl/wb_mem_slave_burst_pkg.sv
// wb_mem_slave_burst shared types, bus codes and burst address helper.
// Optional ERR on out-of-range addresses: WB_MEM_SLAVE_BURST_ERR_EN.
package wb_mem_slave_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } wb_mem_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Next word address of an incrementing burst; wraps keep upper bits
  function automatic logic [31:0] wb_burst_next_addr(
    input logic [31:0] addr,
    input logic [1:0]  bte
  );
    logic [31:0] n;
    n = addr;
    unique case (bte)
      BTE_LINEAR: n = addr + 32'd1;
      BTE_WRAP4:  n[1:0] = addr[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = addr[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = addr[3:0] + 4'd1;
      default:    n = addr + 32'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_mem_slave_burst_if.sv
// Wishbone B3 bus bundle with registered-feedback burst tags.
// Master drives request fields, slave returns data/ACK/ERR.
interface wb_mem_slave_burst_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [DW/8-1:0] SEL;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, CTI, BTE, CYC, STB, WE, SEL, DAT_W,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, CYC, STB, WE, SEL, DAT_W,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_mem_slave_burst_ram.sv
// Single-port synchronous word RAM with byte-lane writes.
// Read register resets/clears to zero; contents are never reset.
module wb_mem_slave_burst_ram #(
  parameter int    DW        = 32,
  parameter int    AB        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_i,
  input  logic            we_i,
  input  logic            clr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AB-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [2**AB];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rstn && en_i && we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave_burst.sv
// Wishbone RAM slave: classic cycles plus CTI/BTE bursts at 1 beat/clk.
// Define WB_MEM_SLAVE_BURST_ERR_EN to ERR on out-of-range addresses.
module wb_mem_slave_burst
  import wb_mem_slave_burst_pkg::*;
#(
  parameter int    WB_ADDR_WIDTH = 32,
  parameter int    WB_DATA_WIDTH = 32,
  parameter int    MEM_ADDR_BITS = 10,
  parameter string INIT_FILE     = ""
) (
  input logic                 clk,
  input logic                 rstn,
  wb_mem_slave_burst_if.slave s
);

  localparam int SW  = WB_DATA_WIDTH / 8;
  localparam int BL  = $clog2(SW);
  localparam int WAW = WB_ADDR_WIDTH - BL;

  wb_mem_state_e state_q, state_d;

  logic [WAW-1:0]           addr_q, addr_d;
  logic [WAW-1:0]           adr_word, nxt_word;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     req, beat, eob;
  logic                     oor_adr, oor_nxt;
  logic                     rd_en, ram_we, ram_en, ram_clr;
  logic [MEM_ADDR_BITS-1:0] rd_addr, ram_addr;
  logic [WB_DATA_WIDTH-1:0] rdata;

  assign req      = s.CYC & s.STB;
  assign beat     = req & ack_q;
  assign eob      = (s.CTI != CTI_INCR);
  assign adr_word = s.ADR[WB_ADDR_WIDTH-1:BL];
  assign nxt_word = WAW'(wb_burst_next_addr(32'(addr_q), s.BTE));

`ifdef WB_MEM_SLAVE_BURST_ERR_EN
  assign oor_adr = |adr_word[WAW-1:MEM_ADDR_BITS];
  assign oor_nxt = |nxt_word[WAW-1:MEM_ADDR_BITS];
`else
  assign oor_adr = 1'b0;
  assign oor_nxt = 1'b0;
`endif

  // State, burst address and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (s.CTI == CTI_INCR && !oor_adr) state_d = BURST;
          else                               state_d = SINGLE;
        end
      end
      SINGLE: state_d = IDLE;
      BURST: begin
        if (!s.CYC)              state_d = IDLE;
        else if (beat && eob)     state_d = IDLE;
        else if (beat && oor_nxt) state_d = SINGLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response, address counter and read-port control
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    ram_clr = 1'b0;
    rd_addr = adr_word[MEM_ADDR_BITS-1:0];
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = adr_word;
          if (oor_adr) begin
            err_d   = 1'b1;
            ram_clr = 1'b1;
          end else begin
            ack_d = 1'b1;
            rd_en = 1'b1;
          end
        end
      end
      BURST: begin
        // Master wait states keep ack_q and the prefetched word
        if (s.CYC) begin
          ack_d = ack_q;
          if (beat) begin
            if (eob) begin
              ack_d = 1'b0;
            end else begin
              addr_d = nxt_word;
              if (oor_nxt) begin
                ack_d   = 1'b0;
                err_d   = 1'b1;
                ram_clr = 1'b1;
              end else begin
                rd_en   = 1'b1;
                rd_addr = nxt_word[MEM_ADDR_BITS-1:0];
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Write the beat on the bus whenever it is (being) acknowledged
  assign ram_we   = req & s.WE & (ack_d | ack_q) & ~oor_adr;
  assign ram_en   = rd_en | ram_we;
  assign ram_addr = ram_we ? adr_word[MEM_ADDR_BITS-1:0] : rd_addr;

  wb_mem_slave_burst_ram #(
    .DW        (WB_DATA_WIDTH),
    .AB        (MEM_ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .clr_i   (ram_clr),
    .be_i    (s.SEL),
    .addr_i  (ram_addr),
    .wdata_i (s.DAT_W),
    .rdata_o (rdata)
  );

  // Registered responses, qualified by a live strobe
  assign s.ACK   = ack_q & req;
  assign s.ERR   = err_q & req;
  assign s.DAT_R = rdata;

endmodule

// File: tb/tb_wb_mem_slave_burst.sv
// Directed bench for wb_mem_slave_burst: classic, bursts, waits, aborts.
// Out-of-range expectations follow WB_MEM_SLAVE_BURST_ERR_EN.
module tb_wb_mem_slave_burst;
  import wb_mem_slave_burst_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_mem_slave_burst_if #(.AW(32), .DW(32)) bus ();

  wb_mem_slave_burst #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .MEM_ADDR_BITS (10),
    .INIT_FILE     ("")
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cyc, input logic stb,
                       input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [2:0] cti, input logic [1:0] bte);
    bus.CYC   = cyc;
    bus.STB   = stb;
    bus.WE    = we;
    bus.ADR   = adr;
    bus.DAT_W = dat;
    bus.SEL   = sel;
    bus.CTI   = cti;
    bus.BTE   = bte;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  // Present one beat just after a rising edge, wait for the response
  task automatic beat(input string tag, input logic [31:0] adr,
                      input logic [2:0] cti, input logic [1:0] bte,
                      input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input int exp_wait,
                      input logic exp_err, input logic chk_rd,
                      input logic [31:0] exp_rd);
    int n;
    drive(1'b1, 1'b1, we, adr, dat, sel, cti, bte);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ACK || bus.ERR || n >= 8) break;
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, ".wait"}, 32'(n), 32'(exp_wait));
    check({tag, ".ack"}, 32'(bus.ACK), 32'(!exp_err));
    check({tag, ".err"}, 32'(bus.ERR), 32'(exp_err));
    if (chk_rd) check({tag, ".rd"}, bus.DAT_R, exp_rd);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] adr,
                    input logic [31:0] exp);
    beat(tag, adr, CTI_CLASSIC, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         1, 1'b0, 1'b1, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] adr,
                    input logic [31:0] dat, input logic [3:0] sel);
    beat(tag, adr, CTI_CLASSIC, BTE_LINEAR, 1'b1, dat, sel,
         1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with a request held on the bus
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    repeat (2) @(negedge clk);
    check("rst.ack", 32'(bus.ACK), 32'h0);
    check("rst.err", 32'(bus.ERR), 32'h0);
    check("rst.dat", bus.DAT_R, 32'h0);
    idle();
    #3 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d.ack", i), 32'(bus.ACK), 32'h0);
    end
    @(posedge clk);
    #1;

    // Classic accesses, back to back (wait=1 proves the dead cycle)
    wr("w_full", 32'h10, 32'hDEADBEEF, 4'hF);
    wr("w_lane1", 32'h10, 32'h0000AA00, 4'b0010);
    rd("r_merge", 32'h10, 32'hDEADAAEF);
    idle();
    @(posedge clk);
    #1;

    // Linear write burst preloads words 0..7 with their index
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("pre%0d", i), 32'(4 * i),
           (i == 7) ? CTI_EOB : CTI_INCR, BTE_LINEAR, 1'b1,
           32'(i), 4'hF, (i == 0) ? 1 : 0, 1'b0, 1'b0, 32'h0);
    end
    rd("r_w7", 32'h1C, 32'h7);
    rd("r_w0", 32'h0, 32'h0);
    idle();
    @(posedge clk);
    #1;

    // Linear read burst @0x8
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("lin%0d", i), 32'(8 + 4 * i),
           (i == 3) ? CTI_EOB : CTI_INCR, BTE_LINEAR, 1'b0,
           32'h0, 4'h0, (i == 0) ? 1 : 0, 1'b0, 1'b1, 32'(2 + i));
    end
    idle();
    @(negedge clk);
    check("lin.after", 32'(bus.ACK), 32'h0);
    @(posedge clk);
    #1;

    // Wrap-4 read burst @0xC -> 3,0,1,2
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("w4_%0d", i), 32'(4 * ((3 + i) % 4)),
           (i == 3) ? CTI_EOB : CTI_INCR, BTE_WRAP4, 1'b0,
           32'h0, 4'h0, (i == 0) ? 1 : 0, 1'b0, 1'b1,
           32'((3 + i) % 4));
    end
    idle();
    @(posedge clk);
    #1;

    // Wrap-8 read burst @0x1C -> 7,0..6
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("w8_%0d", i), 32'(4 * ((7 + i) % 8)),
           (i == 7) ? CTI_EOB : CTI_INCR, BTE_WRAP8, 1'b0,
           32'h0, 4'h0, (i == 0) ? 1 : 0, 1'b0, 1'b1,
           32'((7 + i) % 8));
    end
    idle();
    @(posedge clk);
    #1;

    // Master wait states between beats 2 and 3
    beat("mw0", 32'h0, CTI_INCR, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         1, 1'b0, 1'b1, 32'h0);
    beat("mw1", 32'h4, CTI_INCR, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         0, 1'b0, 1'b1, 32'h1);
    bus.STB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("mw_wait%0d.ack", i), 32'(bus.ACK), 32'h0);
      @(posedge clk);
      #1;
    end
    beat("mw2", 32'h8, CTI_INCR, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         0, 1'b0, 1'b1, 32'h2);
    beat("mw3", 32'hC, CTI_EOB, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         0, 1'b0, 1'b1, 32'h3);
    idle();
    @(posedge clk);
    #1;

    // CYC dropped while a write burst beat is pending
    beat("ab0", 32'h0, CTI_INCR, BTE_LINEAR, 1'b1, 32'hCAFE0000, 4'hF,
         1, 1'b0, 1'b0, 32'h0);
    beat("ab1", 32'h4, CTI_INCR, BTE_LINEAR, 1'b1, 32'hCAFE0001, 4'hF,
         0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hCAFE0002, 4'hF, CTI_INCR,
          BTE_LINEAR);
    @(negedge clk);
    check("ab.ack", 32'(bus.ACK), 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
    rd("ab_r0", 32'h0, 32'hCAFE0000);
    rd("ab_r1", 32'h4, 32'hCAFE0001);
    rd("ab_r2", 32'h8, 32'h2);

    // Address beyond the RAM
`ifdef WB_MEM_SLAVE_BURST_ERR_EN
    beat("oor_rd", 32'h1000, CTI_CLASSIC, BTE_LINEAR, 1'b0, 32'h0,
         4'h0, 1, 1'b1, 1'b1, 32'h0);
    beat("oor_wr", 32'h1000, CTI_CLASSIC, BTE_LINEAR, 1'b1,
         32'hFFFFFFFF, 4'hF, 1, 1'b1, 1'b0, 32'h0);
    rd("oor_keep", 32'h0, 32'hCAFE0000);
`else
    beat("alias_rd", 32'h1000, CTI_CLASSIC, BTE_LINEAR, 1'b0, 32'h0,
         4'h0, 1, 1'b0, 1'b1, 32'hCAFE0000);
`endif

    // Asynchronous reset in the middle of a read burst
    beat("ar0", 32'h0, CTI_INCR, BTE_LINEAR, 1'b0, 32'h0, 4'h0,
         1, 1'b0, 1'b1, 32'hCAFE0000);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
    #2 rstn = 1'b0;
    #1;
    check("ar.ack", 32'(bus.ACK), 32'h0);
    check("ar.err", 32'(bus.ERR), 32'h0);
    check("ar.dat", bus.DAT_R, 32'h0);
    idle();
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    rd("ar_keep", 32'h4, 32'hCAFE0001);
    idle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
